perip_bus_master: RTL
=====================

// Module: perip_bus_master
// PURPOSE
//  Initiator side of the peripheral register interface (sel/addr/wdata/wen -> rdata, registered read).
//  Takes single CPU load/store requests over a valid/ready handshake and decodes the target slave.
//  Drives the chosen peripheral's register port, waits out its read latency, then returns data or an error.
//  Sits between the core's data-memory mux and peripherals such as the system timer.
// PARAMETERS
//  NSLV     4        number of peripheral slots (1..16)
//  BASE_HI  16'h1000 req_addr[31:16] value of the peripheral region
//  RD_LAT   1        cycles from first sel cycle until slave rdata is valid (>=1)
//  AW       3        peripheral register word-address width
// PORTS
//  clk        in   1        system clock
//  rst        in   1        synchronous reset, active-high
//  req_valid  in   1        CPU request valid
//  req_ready  out  1        request accepted when req_valid & req_ready
//  req_addr   in   32       byte address
//  req_wen    in   1        1 = write, 0 = read
//  req_wdata  in   32       write data
//  rsp_valid  out  1        response valid, held until rsp_ready
//  rsp_ready  in   1        CPU accepts the response
//  rsp_rdata  out  32       read data (0 for writes and errors)
//  rsp_err    out  1        unmapped or misaligned access
//  p_sel      out  NSLV     one-hot peripheral select
//  p_addr     out  AW       register word address = req_addr[AW+1:2]
//  p_wdata    out  32       write data to the peripheral
//  p_wen      out  1        write enable, shared by all slots and qualified by p_sel
//  p_rdata    in   NSLV*32  slot k read data on bits [32k+31:32k]; registered by the slave
// BEHAVIOUR
//  Reset: state IDLE; p_sel=0, p_wen=0, p_addr=0, p_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  Reset release: req_ready=1 in the first cycle after reset is released.
//  req_ready = (state==IDLE). Accepting a request latches addr, wen and wdata.
//  Decode: hit when addr[31:16]==BASE_HI, idx=addr[15:12] < NSLV and addr[1:0]==0. Anything else is an error.
//  States: IDLE, ACCESS, WAIT, RESP. Cycle 0 is the accept edge.
//   error: IDLE->RESP. p_sel is never asserted. rsp_valid=1 and rsp_err=1 from cycle 1.
//   write: cycle 1 is ACCESS with p_sel[idx]=1, p_wen=1, p_addr and p_wdata valid. Exactly one cycle.
//          Then RESP; rsp_valid from cycle 2 with rsp_err=0 and rsp_rdata=0.
//   read:  ACCESS, then WAIT for RD_LAT cycles, driven by a down-counter of width clog2(RD_LAT+1).
//          p_sel[idx]=1, p_wen=0 and p_addr stay stable for cycles 1..1+RD_LAT.
//          p_rdata slice idx is captured at the end of cycle 1+RD_LAT.
//          rsp_valid from cycle 2+RD_LAT. p_sel drops in the same cycle.
//  RESP: rsp_* held stable until rsp_valid & rsp_ready, then IDLE.
//   No new request is accepted in the response cycle, so back-to-back requests cost one IDLE cycle.
//  Idle bus: p_sel=0 and p_wen=0 outside ACCESS/WAIT. p_addr and p_wdata hold their last value.
//  Side effects: a read selects a slave for exactly 1+RD_LAT cycles. This matters for slaves with read-side effects.
//   The timer clears COUNTFLAG on sel of CTRL.
//  Reset mid-operation: the next edge returns to the reset state. Any pending response is discarded.
//   p_sel and p_wen are 0 in the cycle after rst.
//  req_valid while busy: ignored; the requester must hold it. Inputs other than p_rdata are not sampled outside IDLE.
// STRUCTURE
//  Package perip_bus_pkg:
//   state enum (IDLE, ACCESS, WAIT, RESP) and PERIP_BASE_HI.
//   slot indices (SLV_TIMER=0, ...).
//   timer register offsets (CTRL=0, LOAD_L=1, VAL_L=2, LOAD_H=3, VAL_H=4).
//  Sub-module perip_addr_decode: combinational addr -> {hit, idx, one-hot sel}.
//   Reused by the instruction-side checker.
//  FSM, latency counter and response registers stay in perip_bus_master.
// TESTING
//  T1 write 0x1000_0004 = 999 ->
//     cycle 1: p_sel=0001, p_addr=1, p_wen=1 for one cycle.
//     cycle 2: rsp_valid=1, rsp_err=0.
//  T2 read 0x1000_0000, registered slave model returning 0x0001_0003 ->
//     p_sel=0001 in cycles 1-2, rsp_rdata=0x0001_0003 in cycle 3.
//  T3 reads of 0x2000_0000, 0x1000_5000 (idx>=NSLV) and 0x1000_0006 ->
//     rsp_err=1, rsp_rdata=0 in cycle 1, p_sel stays 0.
//  T4 rsp_ready low for 5 cycles after T2 ->
//     rsp_* stable, req_ready=0, a competing req_valid is not accepted.
//  T5 RD_LAT=3, read slot 1 returning 0xA5A5_0001 ->
//     p_sel=0010 in cycles 1-4, rsp_valid in cycle 5 with the correct data.
//  T6 rst=1 in cycle 2 of a read ->
//     cycle 3: p_sel=0, rsp_valid=0, req_ready=1 after release, no stale response.

Source files
------------

// File: rtl/perip_bus_pkg.sv
// Shared types and constants for the peripheral register bus: FSM states,
// region base, slot map and system-timer register offsets.
package perip_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam logic [15:0] PERIP_BASE_HI = 16'h1000;

    localparam int SLV_TIMER = 0;

    localparam logic [2:0] TMR_CTRL   = 3'd0;
    localparam logic [2:0] TMR_LOAD_L = 3'd1;
    localparam logic [2:0] TMR_VAL_L  = 3'd2;
    localparam logic [2:0] TMR_LOAD_H = 3'd3;
    localparam logic [2:0] TMR_VAL_H  = 3'd4;

endpackage

// File: rtl/perip_addr_decode.sv
// Combinational peripheral address decoder: byte address -> hit, slot index
// and one-hot select. Shared with the instruction-side access checker.
module perip_addr_decode
    import perip_bus_pkg::*;
#(
    parameter int          NSLV    = 4,
    parameter logic [15:0] BASE_HI = PERIP_BASE_HI
) (
    input  logic [31:0]     addr,
    output logic            hit,
    output logic [3:0]      idx,
    output logic [NSLV-1:0] sel
);

    // The register offset bits do not take part in slot selection.
    logic unused_offset;
    assign unused_offset = ^addr[11:2];

    always_comb begin
        idx = addr[15:12];
        hit = (addr[31:16] == BASE_HI) && (32'(idx) < NSLV) && (addr[1:0] == 2'b00);
        sel = '0;
        for (int k = 0; k < NSLV; k++) begin
            sel[k] = hit && (idx == 4'(k));
        end
    end

endmodule

// File: rtl/perip_bus_master.sv
// Initiator for the peripheral register bus: accepts one CPU load/store,
// drives the decoded slave for its read latency and returns data or an error.
module perip_bus_master
    import perip_bus_pkg::*;
#(
    parameter int          NSLV    = 4,
    parameter logic [15:0] BASE_HI = PERIP_BASE_HI,
    parameter int          RD_LAT  = 1,
    parameter int          AW      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_wen,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [NSLV-1:0]   p_sel,
    output logic [AW-1:0]     p_addr,
    output logic [31:0]       p_wdata,
    output logic              p_wen,
    input  logic [NSLV*32-1:0] p_rdata
);

    localparam int CW = $clog2(RD_LAT + 1);

    state_t          state, state_nxt;
    logic            wen_q;
    logic [NSLV-1:0] sel_q;
    logic [CW-1:0]   cnt;
    logic            dec_hit;
    logic [3:0]      unused_idx;
    logic [NSLV-1:0] dec_sel;
    logic [31:0]     rd_mux;
    logic            last_wait;

    perip_addr_decode #(
        .NSLV    (NSLV),
        .BASE_HI (BASE_HI)
    ) u_decode (
        .addr (req_addr),
        .hit  (dec_hit),
        .idx  (unused_idx),
        .sel  (dec_sel)
    );

    assign last_wait = (cnt == CW'(1));

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (sel_q[k]) rd_mux = rd_mux | p_rdata[32*k +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        p_sel     = '0;
        p_wen     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = dec_hit ? ACCESS : RESP;
            end
            ACCESS: begin
                p_sel     = sel_q;
                p_wen     = wen_q;
                state_nxt = wen_q ? RESP : WAIT;
            end
            WAIT: begin
                p_sel = sel_q;
                if (last_wait) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, read-latency counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_addr    <= '0;
            p_wdata   <= '0;
            wen_q     <= 1'b0;
            sel_q     <= '0;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        p_addr    <= req_addr[AW+1:2];
                        p_wdata   <= req_wdata;
                        wen_q     <= req_wen;
                        sel_q     <= dec_sel;
                        rsp_err   <= ~dec_hit;
                        rsp_rdata <= '0;
                    end
                end
                ACCESS: cnt <= CW'(RD_LAT);
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (last_wait) rsp_rdata <= rd_mux;
                end
                default: ;
            endcase
        end
    end

endmodule
